// File: rtl/icmp_echo_tx.sv
// ICMP echo-reply transmitter: buffers the echo payload, computes the RFC 792
// checksum, then streams the 8-byte header and payload once the IP header is done.
module icmp_echo_tx #(
  parameter int         MAX_PAYLOAD = 64,
  parameter logic [7:0] ICMP_TYPE   = 8'h00,
  parameter logic [7:0] ICMP_CODE   = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_id,
  input  logic [15:0] req_seq,
  input  logic [15:0] req_len,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        hdr_start,
  input  logic        ip_hdr_done,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        tx_done,
  output logic        len_err
);

  localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FOLD,
    ST_WAIT_IP,
    ST_SEND_HDR,
    ST_SEND_PL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] id_q, id_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] len_q, len_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic        fold_cnt_q, fold_cnt_d;
  logic [15:0] csum_q, csum_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        tx_done_q, tx_done_d;
  logic        len_err_q, len_err_d;
  logic        hdr_start_q, hdr_start_d;
  logic        req_ready_q, req_ready_d;
  logic        s_tready_q, s_tready_d;

  logic [7:0]  mem [MAX_PAYLOAD];
  logic [7:0]  rd_data_q;
  logic        mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  logic [31:0] folded;
  logic [2:0]  hdr_nidx;
  logic [7:0]  hdr_nbyte;

  assign req_ready = req_ready_q;
  assign s_tready  = s_tready_q;
  assign hdr_start = hdr_start_q;
  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign tx_done   = tx_done_q;
  assign len_err   = len_err_q;
  assign wr_addr   = wr_ptr_q[AW-1:0];

  always_comb begin
    hdr_nidx = hdr_idx_q + 3'd1;
    case (hdr_nidx)
      3'd0:    hdr_nbyte = ICMP_TYPE;
      3'd1:    hdr_nbyte = ICMP_CODE;
      3'd2:    hdr_nbyte = csum_q[15:8];
      3'd3:    hdr_nbyte = csum_q[7:0];
      3'd4:    hdr_nbyte = id_q[15:8];
      3'd5:    hdr_nbyte = id_q[7:0];
      3'd6:    hdr_nbyte = seq_q[15:8];
      default: hdr_nbyte = seq_q[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    seq_d       = seq_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fold_cnt_d  = fold_cnt_q;
    csum_d      = csum_q;
    hdr_idx_d   = hdr_idx_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    tx_done_d   = 1'b0;
    len_err_d   = 1'b0;
    hdr_start_d = 1'b0;
    mem_we      = 1'b0;
    folded      = {16'b0, sum_q[31:16]} + {16'b0, sum_q[15:0]};

    case (state_q)
      ST_IDLE: begin
        rd_ptr_d  = '0;
        hdr_idx_d = '0;
        if (req_valid && req_ready_q) begin
          id_d       = req_id;
          seq_d      = req_seq;
          len_d      = req_len;
          wr_ptr_d   = '0;
          fold_cnt_d = 1'b0;
          sum_d      = {16'b0, ICMP_TYPE, ICMP_CODE} + {16'b0, req_id} + {16'b0, req_seq};
          if ({1'b0, req_len} > MAX_LEN) begin
            len_err_d = 1'b1;
          end else if (req_len == 16'd0) begin
            state_d = ST_FOLD;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (s_tvalid && s_tready_q) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 16'd1;
          // Even offsets are the high byte of a 16-bit word; odd length pads with zero.
          if (!wr_ptr_q[0]) sum_d = sum_q + {16'b0, s_tdata, 8'b0};
          else              sum_d = sum_q + {24'b0, s_tdata};
          if (wr_ptr_q + 16'd1 == len_q) begin
            state_d    = ST_FOLD;
            fold_cnt_d = 1'b0;
          end
        end
      end

      ST_FOLD: begin
        sum_d = folded;
        if (!fold_cnt_q) begin
          fold_cnt_d  = 1'b1;
          hdr_start_d = 1'b1;
        end else begin
          csum_d  = ~folded[15:0];
          state_d = ST_WAIT_IP;
        end
      end

      ST_WAIT_IP: begin
        if (ip_hdr_done) begin
          state_d    = ST_SEND_HDR;
          hdr_idx_d  = '0;
          m_tvalid_d = 1'b1;
          m_tdata_d  = ICMP_TYPE;
          m_tlast_d  = 1'b0;
        end
      end

      ST_SEND_HDR: begin
        if (m_tready) begin
          if (hdr_idx_q == 3'd7) begin
            if (len_q == 16'd0) begin
              state_d    = ST_IDLE;
              m_tvalid_d = 1'b0;
              m_tlast_d  = 1'b0;
              m_tdata_d  = '0;
              tx_done_d  = 1'b1;
            end else begin
              // rd_data_q already holds payload byte 0, so no bubble after the header.
              state_d   = ST_SEND_PL;
              m_tdata_d = rd_data_q;
              m_tlast_d = (len_q == 16'd1);
              rd_ptr_d  = rd_ptr_q + 16'd1;
            end
          end else begin
            hdr_idx_d = hdr_nidx;
            m_tdata_d = hdr_nbyte;
            m_tlast_d = (hdr_nidx == 3'd7) && (len_q == 16'd0);
          end
        end
      end

      ST_SEND_PL: begin
        if (m_tready) begin
          if (m_tlast_q) begin
            state_d    = ST_IDLE;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tdata_d  = '0;
            tx_done_d  = 1'b1;
          end else begin
            m_tdata_d = rd_data_q;
            m_tlast_d = (rd_ptr_q + 16'd1 == len_q);
            rd_ptr_d  = rd_ptr_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    s_tready_d  = (state_d == ST_LOAD);
    rd_addr     = ({1'b0, rd_ptr_d} < MAX_LEN) ? rd_ptr_d[AW-1:0] : '0;
  end

  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_addr] <= s_tdata;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fold_cnt_q  <= 1'b0;
      csum_q      <= '0;
      hdr_idx_q   <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      len_err_q   <= 1'b0;
      hdr_start_q <= 1'b0;
      req_ready_q <= 1'b0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      seq_q       <= seq_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fold_cnt_q  <= fold_cnt_d;
      csum_q      <= csum_d;
      hdr_idx_q   <= hdr_idx_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      tx_done_q   <= tx_done_d;
      len_err_q   <= len_err_d;
      hdr_start_q <= hdr_start_d;
      req_ready_q <= req_ready_d;
      s_tready_q  <= s_tready_d;
    end
  end

endmodule

// File: tb/tb_icmp_echo_tx.sv
// Directed bench for icmp_echo_tx: hand-computed checksums, timing and stall checks.
module tb_icmp_echo_tx;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_id;
  logic [15:0] req_seq;
  logic [15:0] req_len;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        hdr_start;
  logic        ip_hdr_done;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        tx_done;
  logic        len_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] pl [0:71];
  logic [7:0] ex [0:79];

  icmp_echo_tx #(
    .MAX_PAYLOAD(64),
    .ICMP_TYPE  (8'h00),
    .ICMP_CODE  (8'h00)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_seq    (req_seq),
    .req_len    (req_len),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .hdr_start  (hdr_start),
    .ip_hdr_done(ip_hdr_done),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .tx_done    (tx_done),
    .len_err    (len_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One full request; abort_at>0 pulses reset after that many output bytes were accepted.
  task automatic run_frame(input logic [15:0] id, input logic [15:0] seq,
                           input logic [15:0] len, input logic [15:0] csum,
                           input bit stall, input bit early_ip, input int abort_at);
    int  i, hs_t, n, total, txe;
    bit  hold, vdrop, rdy;
    logic [7:0] hd;
    logic       hl;
    total = 8 + int'(len);
    ex[0] = 8'h00; ex[1] = 8'h00;
    ex[2] = csum[15:8]; ex[3] = csum[7:0];
    ex[4] = id[15:8];   ex[5] = id[7:0];
    ex[6] = seq[15:8];  ex[7] = seq[7:0];
    for (int k = 0; k < int'(len); k++) ex[8+k] = pl[k];

    chk("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_id = id; req_seq = seq; req_len = len;
    tick();
    req_valid = 1'b0;

    i = 0; hs_t = -1; vdrop = 1'b0;
    for (int t = 1; t < int'(len) + 12; t++) begin
      if (hdr_start && hs_t < 0) hs_t = t;
      if (m_tvalid) vdrop = 1'b1;
      ip_hdr_done = early_ip && (t == 3);
      if (i < int'(len) && s_tready) begin
        s_tvalid = 1'b1; s_tdata = pl[i]; i++;
      end else begin
        s_tvalid = 1'b0;
      end
      if (hs_t >= 0) break;
      tick();
    end
    s_tvalid = 1'b0; ip_hdr_done = 1'b0;
    chk("hdr_start_time", hs_t, int'(len) + 2);
    chk("payload_consumed", i, int'(len));
    tick();
    chk("hdr_start_pulse", {31'b0, hdr_start}, 0);
    tick();
    chk("no_early_valid", {31'b0, m_tvalid | vdrop}, 0);
    ip_hdr_done = 1'b1;
    tick();
    ip_hdr_done = 1'b0;

    n = 0; hold = 1'b0; vdrop = 1'b0; txe = 0;
    for (int c = 0; c < 2000 && n < total; c++) begin
      if (abort_at > 0 && n == abort_at) begin
        aresetn = 1'b0;
        tick();
        chk("reset_outputs_zero",
            {17'b0, req_ready, s_tready, hdr_start, m_tvalid, m_tlast, m_tdata, tx_done, len_err}, 0);
        aresetn = 1'b1; m_tready = 1'b1;
        tick();
        chk("reset_req_ready", {31'b0, req_ready}, 1);
        chk("reset_no_tx_done", {31'b0, tx_done}, 0);
        chk("reset_no_valid", {31'b0, m_tvalid}, 0);
        return;
      end
      if (!m_tvalid) vdrop = 1'b1;
      if (tx_done) txe++;
      if (hold) begin
        chk("stall_data", {24'b0, m_tdata}, {24'b0, hd});
        chk("stall_last", {31'b0, m_tlast}, {31'b0, hl});
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        chk($sformatf("byte%0d", n), {24'b0, m_tdata}, {24'b0, ex[n]});
        chk($sformatf("last%0d", n), {31'b0, m_tlast}, {31'b0, (n == total - 1)});
        n++;
        hold = 1'b0;
      end else begin
        hold = m_tvalid; hd = m_tdata; hl = m_tlast;
      end
      tick();
    end
    m_tready = 1'b1;
    chk("all_bytes", n, total);
    chk("valid_no_drop", {31'b0, vdrop}, 0);
    chk("no_early_done", txe, 0);
    chk("tx_done", {31'b0, tx_done}, 1);
    chk("valid_after", {31'b0, m_tvalid}, 0);
    chk("req_ready_done", {31'b0, req_ready}, 1);
    tick();
    chk("tx_done_pulse", {31'b0, tx_done}, 0);
  endtask

  initial begin
    bit saw;
    aresetn = 1'b0; req_valid = 1'b0; req_id = '0; req_seq = '0; req_len = '0;
    s_tdata = '0; s_tvalid = 1'b0; ip_hdr_done = 1'b0; m_tready = 1'b1;
    tick(); tick(); tick();
    chk("rst_outputs",
        {17'b0, req_ready, s_tready, hdr_start, m_tvalid, m_tlast, m_tdata, tx_done, len_err}, 0);
    aresetn = 1'b1;
    tick();
    chk("rst_req_ready_rise", {31'b0, req_ready}, 1);

    // even-length payload
    pl[0] = 8'h61; pl[1] = 8'h62; pl[2] = 8'h63; pl[3] = 8'h64;
    run_frame(16'h1234, 16'h0001, 16'd4, 16'h2904, 1'b0, 1'b0, 0);

    // oversize request
    req_valid = 1'b1; req_id = 16'h1111; req_seq = 16'h2222; req_len = 16'd65;
    tick();
    req_valid = 1'b0;
    chk("len_err_pulse", {31'b0, len_err}, 1);
    chk("len_err_req_ready", {31'b0, req_ready}, 1);
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_tready || hdr_start || m_tvalid || len_err) saw = 1'b1;
    end
    chk("len_err_quiet", {31'b0, saw}, 0);

    // odd-length payload
    run_frame(16'h1234, 16'h0001, 16'd3, 16'h2968, 1'b0, 1'b0, 0);

    // zero-length, fold carry to 0x0000
    run_frame(16'hFFFF, 16'hFFFF, 16'd0, 16'h0000, 1'b0, 1'b0, 0);

    // full buffer, random backpressure, early ip_hdr_done
    for (int k = 0; k < 64; k++) pl[k] = 8'(k);
    run_frame(16'hABCD, 16'h0005, 16'd64, 16'h7029, 1'b1, 1'b1, 0);

    // reset during payload, then a clean repeat of the first frame
    pl[0] = 8'h61; pl[1] = 8'h62; pl[2] = 8'h63; pl[3] = 8'h64;
    run_frame(16'h1234, 16'h0001, 16'd4, 16'h2904, 1'b0, 1'b0, 9);
    run_frame(16'h1234, 16'h0001, 16'd4, 16'h2904, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
